// File: rtl/seven_segment_scheduler.sv
// Multiplexes up to four 32-bit debug sources onto the shared seven-segment driver,
// generating its divided clock and reset and rotating source pages automatically or by hand.
module seven_segment_scheduler #(
  parameter int NUM_SRC    = 4,
  parameter int PRESCALE   = 50000,
  parameter int PAGE_TICKS = 1000
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic [NUM_SRC*32-1:0] srcData,
  input  logic [NUM_SRC-1:0]   srcValid,
  input  logic                 autoScan,
  input  logic [1:0]           manualSel,
  input  logic                 manualHi,
  input  logic                 freeze,
  output logic                 displayClk,
  output logic                 dispRst,
  output logic [31:0]          dispIn,
  output logic [3:0]           dispDot,
  output logic                 dispHi
);

  localparam int PW = $clog2(PRESCALE);
  localparam int CW = $clog2(PAGE_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SHOW_LO, SHOW_HI} state_t;

  state_t          stateReg, stateNext;
  logic [1:0]      idxReg, idxNext;
  logic [CW-1:0]   cntReg, cntNext;
  logic            reenterReg, reenterNext;
  logic [PW-1:0]   prescReg;
  logic [1:0]      riseCnt;
  logic            tick, riseTick, anyValid;
  logic [31:0]     srcArr [4];
  logic [3:0]      validPad;
  logic [31:0]     inNext;
  logic [3:0]      dotNext;
  logic            hiNext;

  // Pad the source list to four entries so missing sources read as invalid zeros.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < NUM_SRC) begin : g_src
        assign srcArr[gi]   = srcData[32*gi +: 32];
        assign validPad[gi] = srcValid[gi];
      end else begin : g_none
        assign srcArr[gi]   = '0;
        assign validPad[gi] = 1'b0;
      end
    end
  endgenerate

  assign tick     = (prescReg == PW'(PRESCALE - 1));
  assign riseTick = tick & ~displayClk;
  assign anyValid = |validPad;

  // Lowest valid index at or after start, wrapping; offsets scanned high to low so the nearest wins.
  function automatic logic [1:0] findValid(input logic [1:0] start, input logic [3:0] valid);
    logic [1:0] res;
    logic [1:0] idx;
    res = start;
    for (int off = 3; off >= 0; off--) begin
      idx = start + 2'(off);
      if (valid[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    stateNext   = stateReg;
    idxNext     = idxReg;
    cntNext     = cntReg;
    reenterNext = reenterReg;
    if (!autoScan) begin
      idxNext     = manualSel;
      reenterNext = 1'b1;
    end else if (riseTick) begin
      reenterNext = 1'b0;
      if (!anyValid) begin
        stateNext = IDLE;
        cntNext   = '0;
      end else if (stateReg == IDLE || reenterReg) begin
        stateNext = SHOW_LO;
        idxNext   = findValid(idxReg, validPad);
        cntNext   = '0;
      end else if (!validPad[idxReg]) begin
        stateNext = SHOW_LO;
        idxNext   = findValid(idxReg + 2'd1, validPad);
        cntNext   = '0;
      end else if (cntReg == CW'(PAGE_TICKS - 1)) begin
        cntNext = '0;
        if (stateReg == SHOW_LO) begin
          stateNext = SHOW_HI;
        end else begin
          stateNext = SHOW_LO;
          idxNext   = findValid(idxReg + 2'd1, validPad);
        end
      end else begin
        cntNext = cntReg + CW'(1);
      end
    end
  end

  always_comb begin
    inNext  = '0;
    dotNext = '0;
    hiNext  = 1'b0;
    if (!autoScan) begin
      hiNext = manualHi;
      if (int'(manualSel) < NUM_SRC) begin
        inNext  = srcArr[manualSel];
        dotNext = 4'b0001 << manualSel;
      end
    end else if (stateNext != IDLE && int'(idxNext) < NUM_SRC) begin
      inNext  = srcArr[idxNext];
      dotNext = 4'b0001 << idxNext;
      hiNext  = (stateNext == SHOW_HI);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      prescReg   <= '0;
      displayClk <= 1'b0;
      riseCnt    <= '0;
      dispRst    <= 1'b1;
      stateReg   <= IDLE;
      idxReg     <= '0;
      cntReg     <= '0;
      reenterReg <= 1'b0;
      dispIn     <= '0;
      dispDot    <= '0;
      dispHi     <= 1'b0;
    end else begin
      prescReg   <= tick ? '0 : prescReg + PW'(1);
      displayClk <= displayClk ^ tick;
      if (riseTick && riseCnt != 2'd2) riseCnt <= riseCnt + 2'd1;
      if (riseTick && riseCnt == 2'd1) dispRst <= 1'b0;
      stateReg   <= stateNext;
      idxReg     <= idxNext;
      cntReg     <= cntNext;
      reenterReg <= reenterNext;
      if (!freeze) dispIn <= inNext;
      dispDot    <= dotNext;
      dispHi     <= hiNext;
    end
  end

endmodule
